// File: rtl/global_pkg.sv
// Project-wide boolean constants.
`timescale 1ns/1ps
package global_pkg;
    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;
endpackage

// File: rtl/uart_pkg.sv
// Shared UART types and default frame geometry for the RX and TX paths.
`timescale 1ns/1ps
package uart_pkg;
    localparam int unsigned OVERSAMPLE_DEF = 16;
    localparam int unsigned DATA_BITS_DEF  = 8;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

    typedef logic [$clog2(OVERSAMPLE_DEF)-1:0] rx_tick_t;
    typedef logic [$clog2(DATA_BITS_DEF)-1:0]  bitidx_t;
endpackage

// File: rtl/uart_baud_tick.sv
// Oversampling tick generator: one-cycle pulse every TICK_DIV enabled clocks.
`timescale 1ns/1ps
module uart_baud_tick #(
    parameter int unsigned TICK_DIV = 27
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic tick_o
);
    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] WRAP = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick_o = en_i && (cnt_q == WRAP);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = tick_o ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/uart_rx_oversample.sv
// 8N1 UART receiver with 16x oversampling, sticky byte flag and overrun
// detection; bit timing is phase-aligned to the synchronized start edge.
`timescale 1ns/1ps
module uart_rx_oversample
    import global_pkg::*;
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned BAUD       = 115_200,
    parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEF,
    parameter int unsigned DATA_BITS  = DATA_BITS_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_i,
    input  logic                 clr_i,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_flag,
    output logic                 frame_err,
    output logic                 overrun_err,
    output logic                 busy
);
    localparam int unsigned TICK_DIV = CLK_HZ / (BAUD * OVERSAMPLE);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [TW-1:0] MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] LAST = TW'(OVERSAMPLE - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);

    logic s1_q, s2_q, prev_q;
    logic fall, start, tick;

    rx_state_t            state_q, state_d;
    logic [TW-1:0]        bit_q, bit_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 flag_q, flag_d;
    logic                 ovr_q, ovr_d;
    logic                 ferr_q, ferr_d;

    assign fall  = prev_q & ~s2_q;
    assign start = (state_q == IDLE) & fall;
    assign busy  = (state_q != IDLE);

    uart_baud_tick #(
        .TICK_DIV(TICK_DIV)
    ) u_tick (
        .clk   (clk),
        .rst   (rst),
        .clr_i (start),
        .en_i  (busy),
        .tick_o(tick)
    );

    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        data_d  = data_q;
        flag_d  = flag_q;
        ovr_d   = ovr_q;
        ferr_d  = FALSE;
        if (clr_i) begin
            flag_d = FALSE;
            ovr_d  = FALSE;
        end
        unique case (state_q)
            IDLE: begin
                if (fall) begin
                    state_d = START;
                    bit_d   = '0;
                    idx_d   = '0;
                end
            end
            START: begin
                if (tick) begin
                    if (bit_q == MID) begin
                        bit_d   = '0;
                        state_d = s2_q ? IDLE : DATA;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    bit_d = (bit_q == LAST) ? '0 : bit_q + 1'b1;
                    if (bit_q == LAST) begin
                        shreg_d = {s2_q, shreg_q[DATA_BITS-1:1]};
                        idx_d   = idx_q + 1'b1;
                        if (idx_q == LAST_IDX) begin
                            state_d = STOP;
                        end
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    bit_d = (bit_q == LAST) ? '0 : bit_q + 1'b1;
                    if (bit_q == LAST) begin
                        state_d = IDLE;
                        if (s2_q) begin
                            data_d = shreg_q;
                            flag_d = TRUE;
                            // a clear in this cycle consumes the old byte
                            ovr_d  = ovr_d | (flag_q & ~clr_i);
                        end else begin
                            ferr_d = TRUE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q    <= 1'b1;
            s2_q    <= 1'b1;
            prev_q  <= 1'b1;
            state_q <= IDLE;
            bit_q   <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
            data_q  <= '0;
            flag_q  <= 1'b0;
            ovr_q   <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            s1_q    <= rx_i;
            s2_q    <= s1_q;
            prev_q  <= s2_q;
            state_q <= state_d;
            bit_q   <= bit_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            data_q  <= data_d;
            flag_q  <= flag_d;
            ovr_q   <= ovr_d;
            ferr_q  <= ferr_d;
        end
    end

    assign rx_data     = data_q;
    assign rx_flag     = flag_q;
    assign overrun_err = ovr_q;
    assign frame_err   = ferr_q;
endmodule
